// File: rtl/tocador_nota_pkg.sv
// Shared definitions for the note player: FSM state encoding, note indices
// and the 50 MHz half-period table used to synthesise each tone.
package tocador_nota_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    TOCANDO = 2'd1,
    PAUSA   = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam int HW = 17;

  localparam logic [2:0] NOTE_C4 = 3'd0;
  localparam logic [2:0] NOTE_D4 = 3'd1;
  localparam logic [2:0] NOTE_E4 = 3'd2;
  localparam logic [2:0] NOTE_F4 = 3'd3;
  localparam logic [2:0] NOTE_G4 = 3'd4;
  localparam logic [2:0] NOTE_A4 = 3'd5;
  localparam logic [2:0] NOTE_B4 = 3'd6;
  localparam logic [2:0] NOTE_C5 = 3'd7;

  // Half-period in 50 MHz clock cycles for each note of the scale.
  function automatic logic [HW-1:0] half_per_base(input logic [2:0] idx);
    logic [HW-1:0] h;
    h = 17'd47778;
    case (idx)
      NOTE_C4: h = 17'd95557;
      NOTE_D4: h = 17'd85131;
      NOTE_E4: h = 17'd75843;
      NOTE_F4: h = 17'd71586;
      NOTE_G4: h = 17'd63776;
      NOTE_A4: h = 17'd56818;
      NOTE_B4: h = 17'd50619;
      NOTE_C5: h = 17'd47778;
      default: h = 17'd47778;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tocador_nota_gerador_tom.sv
// Square-wave generator: toggles its output every half_per cycles while enabled,
// and holds counter and output at zero whenever it is disabled.
module tocador_nota_gerador_tom #(
  parameter int HW = 17
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [HW-1:0] half_per,
  output logic          tom
);

  logic [HW-1:0] cnt;
  logic [HW-1:0] limite;

  // A zero half-period would never wrap, so it degrades to toggling every cycle.
  assign limite = (half_per == '0) ? '0 : half_per - HW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      tom <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      tom <= 1'b0;
    end else if (cnt >= limite) begin
      cnt <= '0;
      tom <= ~tom;
    end else begin
      cnt <= cnt + HW'(1);
    end
  end

endmodule

// File: rtl/tocador_nota.sv
// Note player: on a play request it sounds the latched note for DUR_NOTA cycles,
// stays silent for DUR_PAUSA cycles, then pulses muda_nota for one cycle.
module tocador_nota
  import tocador_nota_pkg::*;
#(
  parameter int DUR_NOTA   = 25_000_000,
  parameter int DUR_PAUSA  = 5_000_000,
  parameter int HALF_SHIFT = 0,
  parameter int CW         = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tocar,
  input  logic [2:0] nota,
  input  logic       parar,
  output logic       buzzer,
  output logic       muda_nota,
  output logic       ocupado,
  output logic [2:0] nota_atual,
  output logic [1:0] db_estado
);

  localparam logic [CW-1:0] NOTA_ULT  = CW'(DUR_NOTA - 1);
  localparam logic [CW-1:0] PAUSA_ULT = CW'((DUR_PAUSA > 0) ? DUR_PAUSA - 1 : 0);

  estado_t       estado, estado_prox;
  logic [CW-1:0] dur_cnt;
  logic          tom_en;
  logic [HW-1:0] half_per;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  // parar overrides every transition, including a request arriving in OCIOSO.
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (tocar) estado_prox = TOCANDO;
      TOCANDO: if (dur_cnt == NOTA_ULT) estado_prox = (DUR_PAUSA > 0) ? PAUSA : FIM;
      PAUSA:   if (dur_cnt == PAUSA_ULT) estado_prox = FIM;
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
    if (parar) estado_prox = OCIOSO;
  end

  // Duration counter restarts from zero on every state change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dur_cnt <= '0;
    end else if ((estado_prox == estado) && ((estado == TOCANDO) || (estado == PAUSA))) begin
      dur_cnt <= dur_cnt + CW'(1);
    end else begin
      dur_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nota_atual <= '0;
    end else if ((estado == OCIOSO) && (estado_prox == TOCANDO)) begin
      nota_atual <= nota;
    end
  end

  // Enabling only while staying in TOCANDO makes the exit edge clear the tone to 0.
  assign tom_en   = (estado == TOCANDO) && (estado_prox == TOCANDO);
  assign half_per = half_per_base(nota_atual) >> HALF_SHIFT;

  tocador_nota_gerador_tom #(.HW(HW)) u_gerador_tom (
    .clock    (clock),
    .reset    (reset),
    .enable   (tom_en),
    .half_per (half_per),
    .tom      (buzzer)
  );

  assign muda_nota = (estado == FIM);
  assign ocupado   = (estado != OCIOSO);
  assign db_estado = estado;

endmodule
